// File: rtl/wb_cmd_master_if.sv
// Command/response handshake and Wishbone classic master bus bundle.
// The master modport is the command master's view; slave is the peer's view
// (command source, response sink and Wishbone slave together).
interface wb_cmd_master_if;
    // Command channel
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;

    // Response channel
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;

    // Wishbone classic master side
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    // Aborted-access statistics
    logic [7:0]  err_count;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
        output cmd_ready,
        output rsp_valid, rsp_dat, rsp_err,
        input  rsp_ready,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i,
        output err_count
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
        input  cmd_ready,
        input  rsp_valid, rsp_dat, rsp_err,
        output rsp_ready,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i,
        input  err_count
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Single-outstanding command-to-Wishbone-classic bridge.
// Accepts one command, runs one bus access (with optional strobe timeout),
// then holds the response until the consumer takes it.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic             clk,
    input logic             rst,
    wb_cmd_master_if.master bus
);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    localparam bit          TimeoutEn = (TIMEOUT != 0);
    localparam logic [31:0] CntLast   = TimeoutEn ? 32'(TIMEOUT - 1) : 32'd0;

    state_e      state_q;
    logic [31:0] cnt_q;
    logic        abort;
    logic        done;

    // Only cmd_ready is combinational: it is a pure decode of the state register.
    assign bus.cmd_ready = (state_q == StIdle);

    // Error wins over ack; timeout only fires on a cycle with no slave response.
    always_comb begin
        abort = bus.wbm_err_i ||
                (TimeoutEn && (cnt_q == CntLast) && !bus.wbm_ack_i);
        done  = abort || bus.wbm_ack_i;
    end

    // Main FSM with all bus and response outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= 32'd0;
            bus.wbm_cyc_o <= 1'b0;
            bus.wbm_stb_o <= 1'b0;
            bus.wbm_we_o  <= 1'b0;
            bus.wbm_sel_o <= 4'd0;
            bus.wbm_adr_o <= 32'd0;
            bus.wbm_dat_o <= 32'd0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_dat   <= 32'd0;
            bus.rsp_err   <= 1'b0;
            bus.err_count <= 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        bus.wbm_we_o  <= bus.cmd_we;
                        bus.wbm_adr_o <= bus.cmd_adr;
                        bus.wbm_dat_o <= bus.cmd_dat;
                        bus.wbm_sel_o <= bus.cmd_sel;
                        bus.wbm_cyc_o <= 1'b1;
                        bus.wbm_stb_o <= 1'b1;
                        cnt_q         <= 32'd0;
                        state_q       <= StBus;
                    end
                end
                StBus: begin
                    if (done) begin
                        bus.wbm_cyc_o <= 1'b0;
                        bus.wbm_stb_o <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= abort;
                        // Read data is only meaningful on a clean read ack.
                        bus.rsp_dat   <= (abort || bus.wbm_we_o) ? 32'd0 : bus.wbm_dat_i;
                        if (abort && (bus.err_count != 8'hFF)) begin
                            bus.err_count <= bus.err_count + 8'd1;
                        end
                        state_q       <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state_q       <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: table of accesses driven through a
// behavioural Wishbone slave, scoreboard of expected responses, plus
// hand-written reset and error-saturation sequences.
module tb_wb_cmd_master;

    localparam int unsigned Tmo = 4;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          waits;    // strobe cycles before the slave answers
        logic        ack;
        logic        err;
        logic [31:0] rdat;
        int          bp;       // cycles rsp_ready is held low
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_stb;
    } vec_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wb_cmd_master_if bus ();

    wb_cmd_master #(.TIMEOUT(Tmo)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   exp_errs = 0;
    rsp_t exp_q[$];
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cyc"}, 32'(bus.wbm_cyc_o), 32'd0);
        chk({tag, "_stb"}, 32'(bus.wbm_stb_o), 32'd0);
        chk({tag, "_we"}, 32'(bus.wbm_we_o), 32'd0);
        chk({tag, "_sel"}, 32'(bus.wbm_sel_o), 32'd0);
        chk({tag, "_adr"}, bus.wbm_adr_o, 32'd0);
        chk({tag, "_dat_o"}, bus.wbm_dat_o, 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_dat"}, bus.rsp_dat, 32'd0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        chk({tag, "_err_count"}, 32'(bus.err_count), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    // Drive one command, act as the slave, then collect and score the response.
    task automatic run_vec(input vec_t v, input string tag);
        int          cycles;
        logic        bad;
        logic [31:0] held_dat;
        logic        held_err;
        rsp_t        e;
        rsp_t        got;

        @(negedge clk);
        chk({tag, "_cmd_ready_idle"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = v.we;
        bus.cmd_adr   = v.adr;
        bus.cmd_dat   = v.dat;
        bus.cmd_sel   = v.sel;
        e.dat = v.exp_dat;
        e.err = v.exp_err;
        exp_q.push_back(e);
        if (v.exp_err && exp_errs < 255) exp_errs++;

        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_dat   = ~v.dat;  // bus side must keep the latched copy
        cycles = 0;
        bad    = 1'b0;
        while (bus.wbm_stb_o && cycles < 50) begin
            cycles++;
            if (!bus.wbm_cyc_o || bus.cmd_ready || bus.wbm_we_o !== v.we ||
                bus.wbm_adr_o !== v.adr || bus.wbm_dat_o !== v.dat ||
                bus.wbm_sel_o !== v.sel) bad = 1'b1;
            if (cycles == v.waits + 1) begin
                bus.wbm_ack_i = v.ack;
                bus.wbm_err_i = v.err;
                bus.wbm_dat_i = v.rdat;
            end else begin
                bus.wbm_ack_i = 1'b0;
                bus.wbm_err_i = 1'b0;
                bus.wbm_dat_i = 32'h5A5A_5A5A;
            end
            @(negedge clk);
        end
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;
        chk({tag, "_bus_hold"}, 32'(bad), 32'd0);
        chk({tag, "_stb_cycles"}, 32'(cycles), 32'(v.exp_stb));
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "_cyc_low"}, 32'(bus.wbm_cyc_o), 32'd0);
        chk({tag, "_err_count"}, 32'(bus.err_count), 32'(exp_errs));

        held_dat = bus.rsp_dat;
        held_err = bus.rsp_err;
        bad      = 1'b0;
        for (int i = 0; i < v.bp; i++) begin
            if (!bus.rsp_valid || bus.rsp_dat !== held_dat || bus.rsp_err !== held_err ||
                bus.cmd_ready || bus.wbm_stb_o) bad = 1'b1;
            // Stray slave strobes during the response phase must change nothing.
            bus.wbm_ack_i = (i == 1);
            bus.wbm_err_i = (i == 2);
            bus.wbm_dat_i = 32'hFFFF_0000;
            @(negedge clk);
        end
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;
        if (v.bp > 0) begin
            chk({tag, "_bp_stable"}, 32'(bad), 32'd0);
            chk({tag, "_bp_err_count"}, 32'(bus.err_count), 32'(exp_errs));
        end

        bus.rsp_ready = 1'b1;
        chk({tag, "_rsp_present"}, 32'(bus.rsp_valid), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            got.dat = bus.rsp_dat;
            got.err = bus.rsp_err;
            chk({tag, "_rsp_dat"}, got.dat, e.dat);
            chk({tag, "_rsp_err"}, 32'(got.err), 32'(e.err));
        end
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_cmd_ready_back"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        vec_t v;

        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = 32'd0;
        bus.cmd_dat   = 32'd0;
        bus.cmd_sel   = 4'd0;
        bus.rsp_ready = 1'b0;
        bus.wbm_dat_i = 32'd0;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;

        //         we    adr            dat            sel   wt ack   err   rdat           bp exp_dat        err   stb
        vecs[0] = '{1'b0, 32'h3000_0004, 32'h0000_0000, 4'hF, 2, 1'b1, 1'b0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0, 3};
        vecs[1] = '{1'b1, 32'h1000_0000, 32'h1234_5678, 4'hF, 0, 1'b1, 1'b0, 32'hAAAA_5555, 0, 32'h0000_0000, 1'b0, 1};
        vecs[2] = '{1'b0, 32'h2000_0010, 32'h0000_0001, 4'h3, 0, 1'b0, 1'b0, 32'h1111_1111, 0, 32'h0000_0000, 1'b1, 4};
        vecs[3] = '{1'b0, 32'h2000_0020, 32'h0000_0002, 4'hF, 1, 1'b1, 1'b1, 32'h2222_2222, 0, 32'h0000_0000, 1'b1, 2};
        vecs[4] = '{1'b0, 32'h2000_0030, 32'h0000_0003, 4'h1, 0, 1'b0, 1'b1, 32'h3333_3333, 0, 32'h0000_0000, 1'b1, 1};
        vecs[5] = '{1'b0, 32'h4000_0040, 32'h0000_0004, 4'hC, 1, 1'b1, 1'b0, 32'hCAFE_F00D, 5, 32'hCAFE_F00D, 1'b0, 2};
        vecs[6] = '{1'b0, 32'h4000_0050, 32'h0000_0005, 4'hF, 3, 1'b1, 1'b0, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 1'b0, 4};

        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Error saturation: 256 more error accesses must pin the counter at 255.
        v = vecs[4];
        for (int i = 0; i < 256; i++) begin
            run_vec(v, "sat");
        end
        chk("sat_final", 32'(bus.err_count), 32'd255);

        // Reset in the middle of a bus access.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b1;
        bus.cmd_adr   = 32'h5000_0000;
        bus.cmd_dat   = 32'h8765_4321;
        bus.cmd_sel   = 4'hA;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("mid_bus_stb", 32'(bus.wbm_stb_o), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("bus_rst");
        exp_errs = 0;

        // Reset while a response is waiting: it must be discarded.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'h7777_7777;
        @(negedge clk);
        bus.wbm_ack_i = 1'b0;
        chk("resp_before_rst", 32'(bus.rsp_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("resp_rst");

        // Normal operation resumes after reset.
        run_vec(vecs[1], "post_rst");
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
